// File: rtl/pwm_pkg.sv
// Shared PWM definitions: default duty width (common with motor_controller),
// capture FSM states and the full-scale duty code.
package pwm_pkg;

  localparam int PWM_DUTY_W = 10;

  localparam logic [PWM_DUTY_W-1:0] DUTY_MAX = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } cap_state_e;

endpackage

// File: rtl/pwm_duty_divider.sv
// Sequential restoring divider: quotient = (numerator << DUTY_W) / denominator,
// one quotient bit per cycle over DUTY_W+1 cycles, saturated to DUTY_W bits.
module pwm_duty_divider #(
  parameter int CNT_W  = 20,
  parameter int DUTY_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  numerator,
  input  logic [CNT_W-1:0]  denominator,
  output logic              busy,
  output logic              done,
  output logic [DUTY_W-1:0] quotient
);

  localparam int STEP_W = $clog2(DUTY_W + 1);

  logic              busy_q, busy_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [CNT_W:0]    rem_q, rem_d, rem_cur, rem_sub;
  logic [CNT_W-1:0]  den_q, den_d, den_cur;
  logic [DUTY_W:0]   quo_q, quo_d;
  logic              ge;

  // numerator <= denominator, so the raw quotient never exceeds 2^DUTY_W
  function automatic logic [DUTY_W-1:0] sat_duty(input logic [DUTY_W:0] q);
    return q[DUTY_W] ? {DUTY_W{1'b1}} : q[DUTY_W-1:0];
  endfunction

  // The start cycle already resolves the MSB straight from the inputs.
  always_comb begin
    rem_cur  = start ? {1'b0, numerator} : rem_q;
    den_cur  = start ? denominator : den_q;
    ge       = (rem_cur >= {1'b0, den_cur});
    rem_sub  = ge ? (rem_cur - {1'b0, den_cur}) : rem_cur;
    rem_d    = {rem_sub[CNT_W-1:0], 1'b0};
    den_d    = den_cur;
    quo_d    = start ? {{DUTY_W{1'b0}}, ge} : {quo_q[DUTY_W-1:0], ge};
    busy_d   = busy_q;
    step_d   = step_q;
    done     = 1'b0;
    if (start) begin
      busy_d = 1'b1;
      step_d = STEP_W'(DUTY_W);
    end else if (busy_q) begin
      step_d = step_q - STEP_W'(1);
      if (step_q == STEP_W'(1)) begin
        busy_d = 1'b0;
        done   = 1'b1;
      end
    end
    quotient = sat_duty(quo_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      step_q <= '0;
    end else begin
      busy_q <= busy_d;
      step_q <= step_d;
    end
  end

  always_ff @(posedge clk) begin
    if (start || busy_q) begin
      rem_q <= rem_d;
      den_q <= den_d;
      quo_q <= quo_d;
    end
  end

  assign busy = busy_q;

endmodule

// File: rtl/pwm_capture.sv
// PWM duty-cycle capture: synchronizer, edge detect, period/high counters and
// divider. Optional glitch filter enabled with `define PWM_CAPTURE_FILTER_EN.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int CNT_W      = 20,
  parameter int DUTY_W     = PWM_DUTY_W,
  parameter int MIN_PERIOD = 16,
  parameter int FILT_LEN   = 4
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              pwm_in,
  output logic [DUTY_W-1:0] duty,
  output logic              duty_valid,
  output logic              timeout,
  output logic              short_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic sync1_q, sync1_d, sync2_q, sync2_d;
  logic s, s_prev_q, s_prev_d;
  logic rise, fall;

  cap_state_e        state_q, state_d;
  logic [CNT_W-1:0]  per_cnt_q, per_cnt_d, hi_cnt_q, hi_cnt_d;
  logic [CNT_W-1:0]  per_q, per_d, hi_q, hi_d, per_meas;
  logic              start_q, start_d, short_q, short_d, tmo_q, tmo_d;
  logic              dv_q, dv_d, sat;
  logic [DUTY_W-1:0] duty_q, duty_d;

  logic              div_busy, div_done;
  logic [DUTY_W-1:0] div_quot;

`ifdef PWM_CAPTURE_FILTER_EN
  localparam int FCW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  logic           filt_q, filt_d;
  logic [FCW-1:0] fcnt_q, fcnt_d;

  // s only follows the synchronizer after FILT_LEN stable cycles
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    if (sync2_q != filt_q) begin
      if (fcnt_q == FCW'(FILT_LEN - 1)) filt_d = sync2_q;
      else                              fcnt_d = fcnt_q + FCW'(1);
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      filt_q <= 1'b0;
      fcnt_q <= '0;
    end else begin
      filt_q <= filt_d;
      fcnt_q <= fcnt_d;
    end
  end

  assign s = filt_q;
`else
  assign s = sync2_q;
`endif

  assign rise     = s & ~s_prev_q;
  assign fall     = ~s & s_prev_q;
  assign per_meas = per_cnt_q + CNT_W'(1);
  assign sat      = (state_q != IDLE) && (per_cnt_q == CNT_MAX);

  always_comb begin
    sync1_d   = pwm_in;
    sync2_d   = sync1_q;
    s_prev_d  = s;
    state_d   = state_q;
    per_cnt_d = per_cnt_q;
    hi_cnt_d  = hi_cnt_q;
    per_d     = per_q;
    hi_d      = hi_q;
    start_d   = 1'b0;
    short_d   = 1'b0;
    tmo_d     = tmo_q;
    duty_d    = duty_q;
    dv_d      = 1'b0;
    if (div_done) begin
      duty_d = div_quot;
      dv_d   = 1'b1;
    end
    // A stuck input overrides any divider result landing in the same cycle.
    if (sat) begin
      tmo_d   = 1'b1;
      duty_d  = s ? {DUTY_W{1'b1}} : {DUTY_W{1'b0}};
      dv_d    = 1'b1;
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (rise) begin
            per_cnt_d = '0;
            hi_cnt_d  = '0;
            tmo_d     = 1'b0;
            state_d   = HIGH;
          end
        end
        HIGH: begin
          per_cnt_d = per_cnt_q + CNT_W'(1);
          hi_cnt_d  = hi_cnt_q + CNT_W'(1);
          if (fall) state_d = LOW;
        end
        LOW: begin
          per_cnt_d = per_cnt_q + CNT_W'(1);
          if (rise) begin
            if (per_meas >= CNT_W'(MIN_PERIOD)) begin
              per_d   = per_meas;
              hi_d    = hi_cnt_q;
              start_d = ~div_busy;
            end else begin
              short_d = 1'b1;
            end
            per_cnt_d = '0;
            hi_cnt_d  = '0;
            state_d   = HIGH;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      s_prev_q  <= 1'b0;
      state_q   <= IDLE;
      per_cnt_q <= '0;
      hi_cnt_q  <= '0;
      start_q   <= 1'b0;
      short_q   <= 1'b0;
      tmo_q     <= 1'b0;
      duty_q    <= '0;
      dv_q      <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      s_prev_q  <= s_prev_d;
      state_q   <= state_d;
      per_cnt_q <= per_cnt_d;
      hi_cnt_q  <= hi_cnt_d;
      start_q   <= start_d;
      short_q   <= short_d;
      tmo_q     <= tmo_d;
      duty_q    <= duty_d;
      dv_q      <= dv_d;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    per_q <= per_d;
    hi_q  <= hi_d;
  end

  pwm_duty_divider #(
    .CNT_W  (CNT_W),
    .DUTY_W (DUTY_W)
  ) u_div (
    .clk         (CLOCK_50),
    .rst         (reset),
    .start       (start_q),
    .numerator   (hi_q),
    .denominator (per_q),
    .busy        (div_busy),
    .done        (div_done),
    .quotient    (div_quot)
  );

  assign duty       = duty_q;
  assign duty_valid = dv_q;
  assign timeout    = tmo_q;
  assign short_err  = short_q;

endmodule

// File: doc/pwm_capture.md
# pwm_capture

Measures the duty cycle of an incoming PWM signal and reports it as a 10-bit value on the same scale that motor_controller accepts: 0 = always low, 1023 = always high. It is the receive end of our PWM path, used to read RC-receiver channels or loop back our own motor drive outputs for self-test. It sits between a GPIO input pin and the control logic that consumes duty values.

## Interface
Parameters:
- CNT_W, 20: period/high-time counter width. At 50 MHz the minimum measurable frequency is about 48 Hz.
- DUTY_W, 10: width of the duty output.
- MIN_PERIOD, 16: periods shorter than this many cycles are rejected. Must exceed DUTY_W+2.
- FILT_LEN, 4: glitch-filter stability length in cycles. Used only with the filter macro.

Ports:
- CLOCK_50  in  1  system clock. The only clock domain.
- reset  in  1  synchronous, active-high reset.
- pwm_in  in  1  asynchronous PWM input from the pin.
- duty  out  DUTY_W  last measured duty, held between updates.
- duty_valid  out  1  one-cycle pulse when duty updates.
- timeout  out  1  level; no rising edge seen for 2^CNT_W−1 cycles.
- short_err  out  1  one-cycle pulse when a period shorter than MIN_PERIOD is rejected.

## Operation
- pwm_in passes through a 2-FF synchronizer to give `s`. A rising or falling edge is detected by comparing `s` with its value one cycle earlier.
- States:
  - IDLE: wait for a rising edge. On a rising edge, clear both counters and go to HIGH.
  - HIGH: per_cnt and hi_cnt increment. On a falling edge, go to LOW.
  - LOW: only per_cnt increments. On a rising edge, latch per = per_cnt+1, then clear both counters and go to HIGH.
- Every latched per with per ≥ MIN_PERIOD starts the divider. The divider computes q = (hi << DUTY_W) / per by restoring division, one quotient bit per cycle, DUTY_W+1 cycles in total.
  - q saturates to 2^DUTY_W−1, so q = 1024 is reported as 1023.
  - On completion, duty is registered and duty_valid pulses.
- Measurement continues in parallel with the divider. MIN_PERIOD guarantees the divider is idle before the next result is needed.
- Short period (per < MIN_PERIOD): pulse short_err, leave duty unchanged, start no division, continue in HIGH.
- Counter saturation: if per_cnt reaches 2^CNT_W−1 in HIGH or LOW:
  - set timeout;
  - force duty to all-ones if `s` = 1, or 0 if `s` = 0;
  - pulse duty_valid once;
  - go to IDLE.
- timeout clears on the next rising edge. duty is not updated again until the next complete period has been measured.
- A saturation event and a divider completion in the same cycle: the saturation value wins, and duty_valid pulses once.
- Reset in any state: return to IDLE, clear counters and abort the divider. Any partial measurement is discarded.
- Reset values: duty=0, duty_valid=0, timeout=0, short_err=0.

## Timing
- Pin to `s`: 2 cycles. Edge detect is combinational from `s`.
- A rising edge detected in cycle e latches per and starts the divider in cycle e+1. duty and duty_valid become visible in cycle e+DUTY_W+2, which is e+12 with default parameters.
- Pin rising edge to duty_valid: 14 cycles without the filter and 14+FILT_LEN cycles with it.
- The first duty_valid after reset or IDLE follows the second rising edge, because one full period is needed.
- timeout and the forced duty appear in the same cycle, one cycle after per_cnt reaches all-ones.

## Configuration
- PWM_CAPTURE_FILTER_EN defined:
  - a glitch filter sits between the synchronizer and edge detection;
  - `s` changes only after the synchronized input has held its new level for FILT_LEN consecutive cycles;
  - pulses shorter than FILT_LEN cycles are ignored.
- Not defined: `s` is the synchronizer output directly. FILT_LEN is unused.

## Structure
- Shared package pwm_pkg holds:
  - DUTY_W default (10), shared with motor_controller;
  - capture state enum (IDLE, HIGH, LOW);
  - DUTY_MAX constant (2^DUTY_W−1).
- Sub-module pwm_duty_divider holds the sequential restoring divider. Interface: start, numerator, denominator, busy, done, quotient (saturating).
- Synchronizer, filter, edge detect, counters and FSM stay in pwm_capture.

## Test plan
- Period 1000 cycles, high 500 → duty=512 after the second rising edge. duty_valid pulses exactly once per period, 14 cycles after each rising edge.
- Period 2000, high 500 → duty=256. Period 1024, high 1 → duty=1.
- Period 20, high 19 → duty=972. Period 15 → short_err pulses, duty unchanged, no duty_valid.
- pwm_in held high after a valid period → after 2^CNT_W−1 cycles, timeout=1 and duty=1023 with one duty_valid. The next full period clears timeout and gives the correct duty.
- Reset asserted mid-HIGH, then a 50% period of 1000 cycles → all outputs 0 during reset. The first duty_valid arrives only after two new rising edges, with duty=512.
- With PWM_CAPTURE_FILTER_EN and FILT_LEN=4: 2-cycle glitches injected in the LOW phase of a 1000/250 signal → duty=256 and no extra periods.
